// File: rtl/jz_board_io_ctrl_pkg.sv
// Shared definitions for the board I/O / reset sequencer.
//   - io_state encodings (IoHold / IoSettle / IoRun)
//   - core reset levels (RstEnable / RstDisable, core reset is active-high)
//   - default switch / LED widths of the board hookup
//   - cnt_w(): width of a counter that must hold 0..n without wrapping
package jz_board_io_ctrl_pkg;

  localparam int SwitchWide = 12;
  localparam int LedWide    = 16;

  localparam logic [1:0] IoHold   = 2'd0;
  localparam logic [1:0] IoSettle = 2'd1;
  localparam logic [1:0] IoRun    = 2'd2;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jz_debounce_ch.sv
// One switch debounce channel.
//   clk, rst : system clock, async active-low reset
//   pin      : raw asynchronous switch pin
//   q        : debounced (stable) level
//   busy     : a change is being qualified (counter != 0)
//   upd      : q takes the sampled value on the coming edge
// The pin passes a 2-flop synchroniser; the synchronised sample must differ
// from q for DEBOUNCE_CYCLES consecutive samples before q follows it.
module jz_debounce_ch
  import jz_board_io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic q,
  output logic busy,
  output logic upd
);

  localparam int             CW     = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] c;

  // c counts differing samples already seen, so c == C_LAST means this
  // sample is the DEBOUNCE_CYCLES-th one; the counter never exceeds C_LAST.
  assign upd  = (s != q) && (c == C_LAST);
  assign busy = (c != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      q     <= 1'b0;
      c     <= '0;
    end else begin
      sync1 <= pin;
      s     <= sync1;
      if (s == q) begin
        c <= '0;
      end else if (upd) begin
        q <= s;
        c <= '0;
      end else begin
        c <= c + CW'(1);
      end
    end
  end

endmodule

// File: rtl/jz_board_io_ctrl.sv
// Board-level I/O and reset sequencer in front of the SOPC core.
//   clk        : system clock
//   rst        : async reset, active-low
//   switch_in  : raw switch pins            switch_on : debounced switches
//   led_in     : LED value from core        led_we    : load led_in
//   core_rst   : core reset, active-high    sw_changed: 1-cycle pulse on switch_on change (RUN)
//   led_out    : registered LED pins        io_state  : HOLD=0 / SETTLE=1 / RUN=2
// Core reset is held for RST_HOLD_CYCLES after rst release (HOLD), then until
// every switch channel is idle (SETTLE); RUN is terminal until rst.
// Build option: define LED_BLINK_EN to drive led_out[LED_WIDTH-1] from a
// heartbeat toggling every BLINK_DIV cycles in RUN.
module jz_board_io_ctrl
  import jz_board_io_ctrl_pkg::*;
#(
  parameter int SW_WIDTH        = SwitchWide,
  parameter int LED_WIDTH       = LedWide,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int BLINK_DIV       = 2**24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  switch_in,
  input  logic [LED_WIDTH-1:0] led_in,
  input  logic                 led_we,
  output logic                 core_rst,
  output logic [SW_WIDTH-1:0]  switch_on,
  output logic                 sw_changed,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [1:0]           io_state
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("RST_HOLD_CYCLES must be >= 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be >= 1");
  end

  logic [SW_WIDTH-1:0] busy_vec;
  logic [SW_WIDTH-1:0] upd_vec;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_ch
    jz_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .pin (switch_in[i]),
      .q   (switch_on[i]),
      .busy(busy_vec[i]),
      .upd (upd_vec[i])
    );
  end

  // ---------------- sequencer ----------------
  localparam int            HW     = cnt_w(RST_HOLD_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(RST_HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic [1:0]    state_nxt;

  always_comb begin
    state_nxt = io_state;
    case (io_state)
      IoHold:   if (hold_cnt == H_LAST) state_nxt = IoSettle;
      IoSettle: if (busy_vec == '0)     state_nxt = IoRun;
      IoRun:    state_nxt = IoRun;
      default:  state_nxt = IoHold;
    endcase
  end

  // core_rst is registered from the next state so it drops on the same edge
  // io_state enters RUN, with no combinational decode on the pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_state   <= IoHold;
      hold_cnt   <= '0;
      core_rst   <= RstEnable;
      sw_changed <= 1'b0;
    end else begin
      io_state   <= state_nxt;
      hold_cnt   <= (io_state == IoHold && hold_cnt != H_LAST) ? hold_cnt + HW'(1) : '0;
      core_rst   <= (state_nxt == IoRun) ? RstDisable : RstEnable;
      // Pulse lands in the cycle switch_on shows the new value.
      sw_changed <= (io_state == IoRun) && (upd_vec != '0);
    end
  end

  // ---------------- LEDs ----------------
  // Uses the current state, so led_we on the SETTLE->RUN edge is dropped.
  logic [LED_WIDTH-1:0] led_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_reg <= '0;
    end else if (io_state != IoRun) begin
      led_reg <= '0;
    end else if (led_we) begin
      led_reg <= led_in;
    end
  end

`ifdef LED_BLINK_EN
  localparam int            BW     = cnt_w(BLINK_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          hb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      hb        <= 1'b0;
    end else if (io_state != IoRun) begin
      blink_cnt <= '0;
      hb        <= 1'b0;
    end else if (blink_cnt == B_LAST) begin
      blink_cnt <= '0;
      hb        <= ~hb;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign led_out = {hb, led_reg[LED_WIDTH-2:0]};
`else
  assign led_out = led_reg;
`endif

endmodule

// File: tb/tb_jz_board_io_ctrl.sv
module tb_jz_board_io_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] switch_in;
  logic [7:0] led_in;
  logic       led_we;
  logic       core_rst;
  logic [3:0] switch_on;
  logic       sw_changed;
  logic [7:0] led_out;
  logic [1:0] io_state;

  int total = 0;
  int bad   = 0;

`ifdef LED_BLINK_EN
  localparam logic [7:0] LMASK = 8'h7F;
`else
  localparam logic [7:0] LMASK = 8'hFF;
`endif

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic [7:0] exp;
  } led_vec_t;

  led_vec_t tbl [0:5];

  jz_board_io_ctrl #(
    .SW_WIDTH       (4),
    .LED_WIDTH      (8),
    .DEBOUNCE_CYCLES(4),
    .RST_HOLD_CYCLES(8),
    .BLINK_DIV      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .switch_in (switch_in),
    .led_in    (led_in),
    .led_we    (led_we),
    .core_rst  (core_rst),
    .switch_on (switch_on),
    .sw_changed(sw_changed),
    .led_out   (led_out),
    .io_state  (io_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts rst away from the clock edge and checks the async reset values.
  task automatic apply_reset(input logic [3:0] sw);
    switch_in = sw;
    led_we    = 1'b0;
    led_in    = 8'h00;
    rst       = 1'b0;
    #1;
    chk("rst core_rst",   32'(core_rst),   32'd1);
    chk("rst io_state",   32'(io_state),   32'd0);
    chk("rst switch_on",  32'(switch_on),  32'd0);
    chk("rst sw_changed", 32'(sw_changed), 32'd0);
    chk("rst led_out",    32'(led_out),    32'd0);
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'h3C, 8'hA5};
    tbl[1] = '{1'b1, 8'h3C, 8'h3C};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF};
    tbl[3] = '{1'b0, 8'h00, 8'hFF};
    tbl[4] = '{1'b1, 8'h00, 8'h00};
    tbl[5] = '{1'b1, 8'h81, 8'h81};

    rst = 1'b0; switch_in = '0; led_in = '0; led_we = 1'b0;
    #12;
    apply_reset(4'b0000);

    // Power-up sequence, with LED writes attempted throughout.
    led_we = 1'b1; led_in = 8'hA5;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("seq io_state", 32'(io_state), (k < 8) ? 32'd0 : (k == 8) ? 32'd1 : 32'd2);
      chk("seq core_rst", 32'(core_rst), (k < 9) ? 32'd1 : 32'd0);
      chk("seq led_out",  32'(led_out & LMASK), (k >= 10) ? 32'(8'hA5 & LMASK) : 32'd0);
    end

    // LED register table in RUN.
    for (int i = 0; i < 6; i++) begin
      led_we = tbl[i].we; led_in = tbl[i].din;
      tick();
      chk("tbl led_out",    32'(led_out & LMASK), 32'(tbl[i].exp & LMASK));
      chk("tbl io_state",   32'(io_state),   32'd2);
      chk("tbl core_rst",   32'(core_rst),   32'd0);
      chk("tbl sw_changed", 32'(sw_changed), 32'd0);
    end
    led_we = 1'b0;

    // 3-cycle glitch on switch 0 is filtered.
    switch_in = 4'b0001;
    repeat (3) tick();
    switch_in = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch switch_on",  32'(switch_on),  32'd0);
      chk("glitch sw_changed", 32'(sw_changed), 32'd0);
    end

    // Held change: accepted on the 6th edge after the pin edge.
    switch_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("held switch_on",  32'(switch_on),  (k >= 6) ? 32'd1 : 32'd0);
      chk("held sw_changed", 32'(sw_changed), (k == 6) ? 32'd1 : 32'd0);
      chk("held io_state",   32'(io_state),   32'd2);
    end

    // Set up switch_on=F, led_out=A5, then reset mid-RUN.
    switch_in = 4'hF; led_we = 1'b1; led_in = 8'hA5;
    repeat (8) tick();
    led_we = 1'b0;
    chk("pre switch_on", 32'(switch_on), 32'hF);
    chk("pre led_out",   32'(led_out & LMASK), 32'(8'hA5 & LMASK));
    apply_reset(4'b0110);

    // Switches held through reset settle during HOLD.
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("heldsw io_state", 32'(io_state), (k < 8) ? 32'd0 : (k == 8) ? 32'd1 : 32'd2);
      chk("heldsw core_rst", 32'(core_rst), (k < 9) ? 32'd1 : 32'd0);
    end
    chk("heldsw switch_on",  32'(switch_on),  32'b0110);
    chk("heldsw sw_changed", 32'(sw_changed), 32'd0);

    // Late switch change stretches SETTLE until the channels are idle.
    apply_reset(4'b0000);
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) switch_in = 4'b0110;
      tick();
      chk("settle io_state",   32'(io_state),   (k < 8) ? 32'd0 : (k <= 10) ? 32'd1 : 32'd2);
      chk("settle core_rst",   32'(core_rst),   (k < 11) ? 32'd1 : 32'd0);
      chk("settle switch_on",  32'(switch_on),  (k >= 10) ? 32'b0110 : 32'd0);
      chk("settle sw_changed", 32'(sw_changed), 32'd0);
    end

    // LED MSB: heartbeat when enabled, plain data bit otherwise.
    led_we = 1'b1; led_in = 8'hFF;
    for (int n = 1; n <= 12; n++) begin
      logic [7:0] e;
`ifdef LED_BLINK_EN
      e = {1'(((n / 4) % 2)), 7'h7F};
`else
      e = 8'hFF;
`endif
      tick();
      chk("msb led_out", 32'(led_out), 32'(e));
    end
    led_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
